// File: rtl/cmb_arbiter.sv
// Round-robin scheduler sharing one combinational cmb instance among NREQ requesters.
// Optional output checker on q/t is built when CMB_ARB_SELFCHECK_EN is defined.
module cmb_arbiter #(
  parameter int NREQ        = 4,
  parameter int EVAL_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_vec,
  output logic [15:0]          cmb_in,
  input  logic [3:0]           cmb_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic [3:0]           rsp_data,
  output logic                 busy,
  output logic                 selfcheck_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  last_grant;
  logic [3:0]  cnt;
  logic [2:0]  winner;
  logic [15:0] win_vec;
  logic        found;
  logic        sample;

  // Search upward from last_grant+1, wrapping; the first requesting index wins.
  always_comb begin
    winner  = '0;
    win_vec = '0;
    found   = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req_valid[k] && (k == (int'(last_grant) + off) % NREQ)) begin
          found   = 1'b1;
          winner  = 3'(k);
          win_vec = req_vec[16*k +: 16];
        end
      end
    end
  end

  assign sample = (state == EVAL) && (cnt == 4'd1);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = (state == IDLE) && !rst && found && (winner == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmb_in     <= '0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 3'(NREQ - 1);
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            cmb_in     <= win_vec;
            rsp_id     <= winner;
            last_grant <= winner;
            cnt        <= 4'(EVAL_CYCLES);
            busy       <= 1'b1;
            state      <= EVAL;
          end
        end
        EVAL: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rsp_data  <= cmb_out;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          // Returning to IDLE costs one cycle before the next grant can be issued.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef CMB_ARB_SELFCHECK_EN
  logic exp_q;
  logic exp_t;
  logic err_reg;

  assign exp_q = &cmb_in[15:4];
  assign exp_t = ~|cmb_in[11:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (sample && ({exp_q, exp_t} != {cmb_out[3], cmb_out[0]})) begin
      err_reg <= 1'b1;
    end
  end

  assign selfcheck_err = err_reg;
`else
  assign selfcheck_err = 1'b0;
`endif

endmodule
